ram_user_port_responder: RTL and testbench

- Memory-side responder for the 16-bit-word user RAM interface that the audio record/playback FSM drives (rdy, address, data_in, write_enable, read_request, read_ack, data_out, rd_data_pres).
- Services writes and reads from an on-chip block-RAM array.
- Provides programmable calibration delay, read latency and write-busy time, so the recorder/player FSM can be simulated and run on boards without the DDR2 controller.
- Exports max_ram_address so the initiator knows the wrap point.

---
 rtl/ram_user_port_responder.sv | 172 +++++++++++++++++
 tb/tb_ram_user_port_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_user_port_responder.sv
// Block-RAM responder for the 16-bit user RAM port used by the record/playback FSM.
// Emulates calibration delay, read latency and write-busy time of the DDR2 path.
module ram_user_port_responder #(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 3,
  parameter int WRITE_BUSY   = 1,
  parameter int INIT_DELAY   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] address,
  input  logic [15:0] data_in,
  input  logic        write_enable,
  input  logic        read_request,
  input  logic        read_ack,
  input  logic        clear_flags,
  output logic        rdy,
  output logic [15:0] data_out,
  output logic        rd_data_pres,
  output logic [25:0] max_ram_address,
  output logic        ledRAM,
  output logic        collision,
  output logic        out_of_range
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WBUSY,
    S_RLAT,
    S_RPRES
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] ridx_q, ridx_d;
  logic [15:0]          dout_q, dout_d;
  logic                 pres_q, pres_d;
  logic                 led_q, led_d;
  logic                 coll_q, coll_d;
  logic                 oor_q, oor_d;

  logic [15:0]          mem [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                 idle;
  logic                 accept;
  logic                 wr_acc;
  logic                 high_nz;

  assign idx     = address[ADDR_BITS-1:0];
  assign idle    = (state_q == S_IDLE);
  assign accept  = idle && (write_enable || read_request);
  assign wr_acc  = idle && write_enable;
  assign high_nz = |address[25:ADDR_BITS];

  // State and output registers; array is deliberately outside reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ridx_q  <= '0;
      dout_q  <= '0;
      pres_q  <= 1'b0;
      led_q   <= 1'b0;
      coll_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ridx_q  <= ridx_d;
      dout_q  <= dout_d;
      pres_q  <= pres_d;
      led_q   <= led_d;
      coll_q  <= coll_d;
      oor_q   <= oor_d;
    end
  end

  // Array write on an accepted write command.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= data_in;
    end
  end

  // Next-state, counters, read data and sticky flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    dout_d  = dout_q;
    pres_d  = pres_q;
    led_d   = led_q;
    coll_d  = coll_q;
    oor_d   = oor_q;

    unique case (state_q)
      S_INIT: begin
        if (cnt_q == 8'(INIT_DELAY - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          led_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_IDLE: begin
        if (write_enable) begin
          if (WRITE_BUSY > 0) begin
            state_d = S_WBUSY;
            cnt_d   = '0;
          end
        end else if (read_request) begin
          state_d = S_RLAT;
          ridx_d  = idx;
          cnt_d   = '0;
        end
      end
      S_WBUSY: begin
        if (cnt_q == 8'(WRITE_BUSY - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RLAT: begin
        if (cnt_q == 8'(READ_LATENCY - 1)) begin
          state_d = S_RPRES;
          dout_d  = mem[ridx_q];
          pres_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RPRES: begin
        if (read_ack) begin
          state_d = S_IDLE;
          pres_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    if (clear_flags) begin
      coll_d = 1'b0;
      oor_d  = 1'b0;
    end
    if (accept && write_enable && read_request) begin
      coll_d = 1'b1;
    end
    if (accept && high_nz) begin
      oor_d = 1'b1;
    end
  end

  assign rdy             = idle;
  assign data_out        = dout_q;
  assign rd_data_pres    = pres_q;
  assign ledRAM          = led_q;
  assign collision       = coll_q;
  assign out_of_range    = oor_q;
  assign max_ram_address = 26'(DEPTH - 1);

endmodule

// File: tb/tb_ram_user_port_responder.sv
// Scoreboard bench for ram_user_port_responder: default instance plus a
// zero write-busy instance for the back-to-back burst.
module tb_ram_user_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] address;
  logic [15:0] data_in;
  logic        we, rr, ack, clr;

  logic        rdy_a, pres_a, led_a, coll_a, oor_a;
  logic [15:0] dout_a;
  logic [25:0] max_a;
  logic        rdy_b, pres_b, led_b, coll_b, oor_b;
  logic [15:0] dout_b;
  logic [25:0] max_b;

  logic        sel;
  logic        rdy_s, pres_s;
  logic [15:0] dout_s;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  assign rdy_s  = sel ? rdy_b  : rdy_a;
  assign pres_s = sel ? pres_b : pres_a;
  assign dout_s = sel ? dout_b : dout_a;

  always #5 clk = ~clk;

  ram_user_port_responder u_dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write_enable(we), .read_request(rr), .read_ack(ack),
    .clear_flags(clr), .rdy(rdy_a), .data_out(dout_a),
    .rd_data_pres(pres_a), .max_ram_address(max_a), .ledRAM(led_a),
    .collision(coll_a), .out_of_range(oor_a)
  );

  ram_user_port_responder #(.WRITE_BUSY(0)) u_wb0 (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write_enable(we), .read_request(rr), .read_ack(ack),
    .clear_flags(clr), .rdy(rdy_b), .data_out(dout_b),
    .rd_data_pres(pres_b), .max_ram_address(max_b), .ledRAM(led_b),
    .collision(coll_b), .out_of_range(oor_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_s) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [25:0] a, input logic [15:0] d);
    wait_rdy();
    address = a;
    data_in = d;
    we      = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [25:0] a, input logic [15:0] e,
                         input int hold);
    int lat = 0;
    logic stable = 1'b1;
    logic [15:0] x = '0;
    wait_rdy();
    exp_q.push_back(e);
    address = a;
    rr      = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    while (!pres_s && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", lat, 3);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      chk("rd_data", {16'd0, dout_s}, {16'd0, x});
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!pres_s || dout_s !== x) stable = 1'b0;
    end
    if (hold > 0) chk("rd_hold", {31'd0, stable}, 32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("rd_drop", {31'd0, pres_s}, 32'd0);
    chk("rdy_back", {31'd0, rdy_s}, 32'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   drops;
    logic seen;
    logic led_early;

    sel = 1'b0; reset = 1'b0; address = '0; data_in = '0;
    we = 1'b0; rr = 1'b0; ack = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  {31'd0, rdy_a},  32'd0);
    chk("rst_led",  {31'd0, led_a},  32'd0);
    chk("rst_pres", {31'd0, pres_a}, 32'd0);
    chk("rst_dout", {16'd0, dout_a}, 32'd0);
    chk("rst_coll", {31'd0, coll_a}, 32'd0);
    chk("rst_oor",  {31'd0, oor_a},  32'd0);
    chk("max_addr", {6'd0, max_a},   32'h0000_0FFF);

    reset = 1'b1;
    n = 0;
    led_early = 1'b0;
    while (!rdy_a && n < 100) begin
      @(negedge clk);
      n++;
      if (!rdy_a && led_a) led_early = 1'b1;
    end
    chk("init_cycles", n, 16);
    chk("led_on", {31'd0, led_a}, 32'd1);
    chk("led_early", {31'd0, led_early}, 32'd0);

    do_write(26'h0000010, 16'hA5C3);
    chk("wbusy_low", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    chk("wbusy_done", {31'd0, rdy_a}, 32'd1);
    do_read(26'h0000010, 16'hA5C3, 5);

    do_write(26'h0001005, 16'h1234);
    chk("oor_set", {31'd0, oor_a}, 32'd1);
    do_read(26'h0000005, 16'h1234, 0);
    chk("oor_sticky", {31'd0, oor_a}, 32'd1);
    pulse_clr();
    chk("oor_clr", {31'd0, oor_a}, 32'd0);

    wait_rdy();
    address = 26'd3; data_in = 16'hBEEF; we = 1'b1; rr = 1'b1;
    @(negedge clk);
    we = 1'b0; rr = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pres_a) seen = 1'b1;
    end
    chk("coll_nopres", {31'd0, seen}, 32'd0);
    chk("coll_set", {31'd0, coll_a}, 32'd1);
    chk("coll_oor", {31'd0, oor_a}, 32'd0);
    do_read(26'd3, 16'hBEEF, 0);
    pulse_clr();
    chk("coll_clr", {31'd0, coll_a}, 32'd0);

    wait_rdy();
    address = 26'd3; data_in = 16'hBEEF; we = 1'b1; rr = 1'b1; clr = 1'b1;
    @(negedge clk);
    we = 1'b0; rr = 1'b0; clr = 1'b0;
    chk("coll_setwins", {31'd0, coll_a}, 32'd1);
    pulse_clr();
    chk("coll_clr2", {31'd0, coll_a}, 32'd0);

    do_write(26'h0000020, 16'h5A5A);
    wait_rdy();
    address = 26'h0000020; rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    @(negedge clk);
    seen = pres_a;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_rdy",  {31'd0, rdy_a},  32'd0);
    chk("rstmid_pres", {31'd0, pres_a}, 32'd0);
    chk("rstmid_led",  {31'd0, led_a},  32'd0);
    reset = 1'b1;
    n = 0;
    while (!rdy_a && n < 100) begin
      @(negedge clk);
      n++;
      if (pres_a) seen = 1'b1;
    end
    chk("reinit_cycles", n, 16);
    chk("abandon_nopres", {31'd0, seen}, 32'd0);
    do_read(26'h0000020, 16'h5A5A, 0);
    do_read(26'h0000010, 16'hA5C3, 0);
    do_read(26'h0000005, 16'h1234, 0);

    sel = 1'b1;
    wait_rdy();
    drops = 0;
    for (int i = 0; i < 256; i++) begin
      address = 26'(i);
      data_in = 16'(i + 1);
      we      = 1'b1;
      @(negedge clk);
      if (!rdy_b) drops++;
    end
    we = 1'b0;
    chk("burst_rdy_drops", drops, 0);
    for (int i = 0; i < 256; i++) begin
      do_read(26'(i), 16'(i + 1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
